// File: rtl/mgmt_command_engine_pkg.sv
// Shared opcode constants, reply codes and FSM/command encodings for the
// management UART command engine.
package mgmt_pkg;

  typedef logic [15:0] opcode_t;

  localparam opcode_t OP_NOP        = 16'h0000;
  localparam opcode_t OP_ECHO       = 16'h0001;
  localparam opcode_t OP_READ_BASE  = 16'h0100;
  localparam opcode_t OP_WRITE_BASE = 16'h0200;
  localparam opcode_t OP_BASE_MASK  = 16'hFF00;

  localparam logic [7:0] REPLY_ACK = 8'h55;
  localparam logic [7:0] REPLY_ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OP_HI    = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_COMMIT   = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_REPLY = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_t;

endpackage

// File: rtl/mgmt_command_engine_serializer.sv
// Reply shadow register: loads an N-byte reply and emits it LSB first, one
// byte per tx_done handshake. tx_data is driven straight from the shadow flops.
module mgmt_byte_serializer #(
  parameter int N_BYTES = 8,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [N_BYTES*8-1:0] load_data,
  input  logic [CNT_W-1:0]     load_len,
  input  logic                 adv,
  input  logic                 clr,
  output logic [7:0]           tx_data,
  output logic                 tx_en,
  output logic                 last
);

  logic [N_BYTES*8-1:0] shadow_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 tx_en_r;

  // Shadow shift register, remaining-byte count and send strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
      cnt_r    <= '0;
      tx_en_r  <= 1'b0;
    end else begin
      tx_en_r <= 1'b0;
      if (clr) begin
        shadow_r <= '0;
        cnt_r    <= '0;
      end else if (load) begin
        shadow_r <= load_data;
        cnt_r    <= load_len;
        tx_en_r  <= 1'b1;
      end else if (adv) begin
        if (cnt_r > CNT_W'(1)) begin
          shadow_r <= shadow_r >> 8;
          cnt_r    <= cnt_r - CNT_W'(1);
          tx_en_r  <= 1'b1;
        end else begin
          shadow_r <= '0;
          cnt_r    <= '0;
        end
      end
    end
  end

  assign tx_data = shadow_r[7:0];
  assign tx_en   = tx_en_r;
  assign last    = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/mgmt_command_engine.sv
// Management UART command engine: opcode decode, coherent read snapshots,
// register writes, error replies and watchdog. Build macro: MGMT_CHECKSUM_EN.
module mgmt_command_engine
  import mgmt_pkg::*;
#(
  parameter int NUM_RD   = 8,
  parameter int RD_BYTES = 8,
  parameter int NUM_WR   = 4,
  parameter int WR_BYTES = 4,
  parameter int WDT_BITS = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [7:0]                                    uart_rx_data,
  input  logic                                          uart_rx_en,
  output logic [7:0]                                    uart_tx_data,
  output logic                                          uart_tx_en,
  input  logic                                          uart_tx_done,
  input  logic [NUM_RD*RD_BYTES*8-1:0]                  rd_regs,
  output logic [(NUM_WR > 1 ? $clog2(NUM_WR) : 1)-1:0]  wr_addr,
  output logic [WR_BYTES*8-1:0]                         wr_data,
  output logic                                          wr_en,
  output logic                                          wdt_timeout
);

  localparam int RD_W  = RD_BYTES * 8;
  localparam int WR_W  = WR_BYTES * 8;
  localparam int WA_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int MAX_B = (RD_BYTES > WR_BYTES) ? RD_BYTES : WR_BYTES;
  localparam int CNT_W = $clog2(MAX_B + 2);
`ifdef MGMT_CHECKSUM_EN
  localparam int CK_BYTES = 1;
`else
  localparam int CK_BYTES = 0;
`endif
  localparam int SER_BYTES = RD_BYTES + CK_BYTES;
  localparam int SER_W     = SER_BYTES * 8;
  localparam int PAY_LAST  = WR_BYTES - 1 + CK_BYTES;

  state_t              state_r, state_s;
  cmd_t                cmd_r, cmd_s;
  logic [7:0]          op_lo_r;
  opcode_t             opcode_s;
  logic                rd_ok_s, wr_ok_s;
  logic [RD_W-1:0]     rd_sel_s;
  logic [CNT_W-1:0]    byte_cnt_r;
  logic [WR_W-1:0]     wr_buf_r, buf_next_s, commit_data_s;
  logic                pay_data_s, pay_last_s;
  logic [WDT_BITS-1:0] wdt_r;
  logic                wdt_hit_s, rx_take_s, done_take_s, commit_s, csum_ok_s;
  logic [WA_W-1:0]     wr_addr_r;
  logic [WR_W-1:0]     wr_data_r;
  logic                wr_en_r, wdt_timeout_r;
  logic                ser_load_s, ser_adv_s, ser_clr_s, ser_last_s;
  logic [SER_W-1:0]    ser_data_s;
  logic [CNT_W-1:0]    ser_len_s;

  // A single-byte reply carries its own value as checksum when enabled
  function automatic logic [SER_W-1:0] reply1(input logic [7:0] r);
`ifdef MGMT_CHECKSUM_EN
    return SER_W'({r, r});
`else
    return SER_W'(r);
`endif
  endfunction

`ifdef MGMT_CHECKSUM_EN
  logic [7:0] csum_r;

  function automatic logic [7:0] xor_bytes(input logic [RD_W-1:0] v);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < RD_BYTES; i++) x = x ^ v[i*8 +: 8];
    return x;
  endfunction

  // Running XOR over opcode and payload bytes of the current transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'h00;
    end else if (state_r == ST_IDLE && uart_rx_en) begin
      csum_r <= uart_rx_data;
    end else if (rx_take_s) begin
      csum_r <= csum_r ^ uart_rx_data;
    end
  end

  assign pay_data_s    = (byte_cnt_r < CNT_W'(WR_BYTES));
  assign csum_ok_s     = (csum_r == uart_rx_data);
  assign commit_data_s = wr_buf_r;
`else
  assign pay_data_s    = 1'b1;
  assign csum_ok_s     = 1'b1;
  assign commit_data_s = buf_next_s;
`endif

  assign opcode_s    = {uart_rx_data, op_lo_r};
  assign rd_ok_s     = (int'(op_lo_r) < NUM_RD);
  assign wr_ok_s     = (int'(op_lo_r) < NUM_WR);
  assign buf_next_s  = (wr_buf_r >> 8) | (WR_W'(uart_rx_data) << (8 * (WR_BYTES - 1)));
  assign pay_last_s  = (byte_cnt_r == CNT_W'(PAY_LAST));
  assign wdt_hit_s   = (state_r != ST_IDLE) && (&wdt_r);
  assign done_take_s = (state_r == ST_TX_WAIT) && uart_tx_done && !wdt_hit_s;

  // Read register mux indexed by the low opcode byte
  always_comb begin
    rd_sel_s = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_sel_s = rd_sel_s | ((int'(op_lo_r) == i) ? rd_regs[i*RD_W +: RD_W] : '0);
  end

  // Next-state, reply loading and write-commit decisions
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    ser_load_s = 1'b0;
    ser_data_s = '0;
    ser_len_s  = '0;
    ser_adv_s  = 1'b0;
    ser_clr_s  = 1'b0;
    commit_s   = 1'b0;
    rx_take_s  = 1'b0;
    if (wdt_hit_s) begin
      state_s   = ST_IDLE;
      ser_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (uart_rx_en) state_s = ST_OP_HI;
          else            state_s = ST_IDLE;
        end
        ST_OP_HI: begin
          if (uart_rx_en) begin
            rx_take_s = 1'b1;
            state_s   = ST_DISPATCH;
            if (opcode_s == OP_NOP) begin
              cmd_s = CMD_NOP;
            end else if (opcode_s == OP_ECHO) begin
              cmd_s      = CMD_REPLY;
              ser_load_s = 1'b1;
              ser_data_s = reply1(REPLY_ACK);
              ser_len_s  = CNT_W'(1 + CK_BYTES);
            end else if ((opcode_s & OP_BASE_MASK) == OP_READ_BASE && rd_ok_s) begin
              cmd_s      = CMD_REPLY;
              ser_load_s = 1'b1;
`ifdef MGMT_CHECKSUM_EN
              ser_data_s = {xor_bytes(rd_sel_s), rd_sel_s};
`else
              ser_data_s = rd_sel_s;
`endif
              ser_len_s  = CNT_W'(SER_BYTES);
            end else if ((opcode_s & OP_BASE_MASK) == OP_WRITE_BASE && wr_ok_s) begin
              cmd_s = CMD_WRITE;
            end else begin
              cmd_s      = CMD_REPLY;
              ser_load_s = 1'b1;
              ser_data_s = reply1(REPLY_ERR);
              ser_len_s  = CNT_W'(1 + CK_BYTES);
            end
          end else begin
            state_s = ST_OP_HI;
          end
        end
        ST_DISPATCH: begin
          case (cmd_r)
            CMD_WRITE: state_s = ST_PAYLOAD;
            CMD_REPLY: state_s = ST_TX_WAIT;
            default:   state_s = ST_IDLE;
          endcase
        end
        ST_PAYLOAD: begin
          if (uart_rx_en) begin
            rx_take_s = 1'b1;
            if (pay_last_s) begin
              state_s    = ST_COMMIT;
              ser_load_s = 1'b1;
              ser_len_s  = CNT_W'(1 + CK_BYTES);
              commit_s   = csum_ok_s;
              ser_data_s = csum_ok_s ? reply1(REPLY_ACK) : reply1(REPLY_ERR);
            end else begin
              state_s = ST_PAYLOAD;
            end
          end else begin
            state_s = ST_PAYLOAD;
          end
        end
        ST_COMMIT: state_s = ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (uart_tx_done) begin
            ser_adv_s = 1'b1;
            state_s   = ser_last_s ? ST_IDLE : ST_TX_WAIT;
          end else begin
            state_s = ST_TX_WAIT;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // FSM state, opcode low byte, payload counter and assembly buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cmd_r      <= CMD_NOP;
      op_lo_r    <= 8'h00;
      byte_cnt_r <= '0;
      wr_buf_r   <= '0;
    end else begin
      state_r <= state_s;
      cmd_r   <= cmd_s;
      if (state_r == ST_IDLE && uart_rx_en) op_lo_r <= uart_rx_data;
      if (state_r == ST_DISPATCH)                    byte_cnt_r <= '0;
      else if (state_r == ST_PAYLOAD && rx_take_s)   byte_cnt_r <= byte_cnt_r + CNT_W'(1);
      if (state_r == ST_PAYLOAD && rx_take_s && pay_data_s) wr_buf_r <= buf_next_s;
    end
  end

  // Write port, watchdog counter and timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r     <= '0;
      wr_data_r     <= '0;
      wr_en_r       <= 1'b0;
      wdt_r         <= '0;
      wdt_timeout_r <= 1'b0;
    end else begin
      wr_en_r       <= commit_s;
      wdt_timeout_r <= wdt_hit_s;
      if (commit_s) begin
        wr_addr_r <= op_lo_r[WA_W-1:0];
        wr_data_r <= commit_data_s;
      end
      if (state_r == ST_IDLE || rx_take_s || done_take_s || wdt_hit_s) wdt_r <= '0;
      else                                                         wdt_r <= wdt_r + WDT_BITS'(1);
    end
  end

  mgmt_byte_serializer #(
    .N_BYTES (SER_BYTES),
    .CNT_W   (CNT_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load_s),
    .load_data (ser_data_s),
    .load_len  (ser_len_s),
    .adv       (ser_adv_s),
    .clr       (ser_clr_s),
    .tx_data   (uart_tx_data),
    .tx_en     (uart_tx_en),
    .last      (ser_last_s)
  );

  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign wr_en       = wr_en_r;
  assign wdt_timeout = wdt_timeout_r;

endmodule
